vga_anim_sequencer: RTL and testbench

//  Animation timing source for the VGA text renderer. Runs in the slow anim_clk domain.

---
 rtl/vga_anim_sequencer_if.sv | 25 ++
 rtl/vga_anim_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_vga_anim_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vga_anim_sequencer_if.sv
// Control and animation-output bundle between the user-control side and the
// animation sequencer.
interface vga_anim_sequencer_if;
   logic       mode_btn;
   logic       freeze;
   logic       dir;
   logic [1:0] speed;
   logic       key_hit;
   logic [5:0] phase;
   logic       fancy;
   logic       cursor_blink;
   logic       phase_wrap;

   // Control source: drives the raw user inputs, observes the animation state.
   modport master (
      output mode_btn, freeze, dir, speed, key_hit,
      input  phase, fancy, cursor_blink, phase_wrap
   );

   // Sequencer side: consumes the raw user inputs, produces the animation state.
   modport slave (
      input  mode_btn, freeze, dir, speed, key_hit,
      output phase, fancy, cursor_blink, phase_wrap
   );
endinterface

// File: rtl/vga_anim_sequencer.sv
// Animation timing source for the VGA text renderer (anim_clk domain).
// Synchronises the user controls, runs the OFF/RUN/HOLD mode machine with its
// colour-phase divider, and generates the cursor blink level.
module vga_anim_sequencer #(
   parameter int PHASE_DIV  = 1,
   parameter int PHASE_STEP = 1,
   parameter int BLINK_HALF = 6
) (
   input  logic                  anim_clk,
   input  logic                  rst,
   vga_anim_sequencer_if.slave   anim
);

   localparam logic [6:0] PHASE_COUNT = 7'd48;
   localparam logic [6:0] STEP        = 7'(PHASE_STEP);
   localparam int         BLINK_W     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Synchroniser stages, bit order {speed[1:0], key_hit, dir, freeze, mode_btn}
   logic [5:0] sync1_r;
   logic [5:0] sync2_r;
   logic       mode_prev_r;
   logic       key_prev_r;
   logic [1:0] speed_prev_r;
   logic       toggle_r;
   logic       key_edge_r;

   logic       freeze_s;
   logic       dir_s;
   logic [1:0] speed_s;

   state_t     state_r;
   logic [5:0] phase_r;
   logic       fancy_r;
   logic       wrap_r;
   logic [5:0] div_cnt_r;

   logic [BLINK_W-1:0] blink_cnt_r;
   logic               blink_r;

   logic [6:0] div_limit_s;
   logic [6:0] div_last_s;
   logic       div_term_s;
   logic       speed_change_s;
   logic [6:0] sum_s;
   logic [5:0] next_phase_s;
   logic       next_wrap_s;

   assign freeze_s = sync2_r[1];
   assign dir_s    = sync2_r[2];
   assign speed_s  = sync2_r[5:4];

   // Two-flop synchronisers plus registered rising-edge pulses for mode and key
   always_ff @(posedge anim_clk) begin
      if (rst) begin
         sync1_r      <= 6'd0;
         sync2_r      <= 6'd0;
         mode_prev_r  <= 1'b0;
         key_prev_r   <= 1'b0;
         speed_prev_r <= 2'd0;
         toggle_r     <= 1'b0;
         key_edge_r   <= 1'b0;
      end else begin
         sync1_r      <= {anim.speed, anim.key_hit, anim.dir, anim.freeze, anim.mode_btn};
         sync2_r      <= sync1_r;
         mode_prev_r  <= sync2_r[0];
         key_prev_r   <= sync2_r[3];
         speed_prev_r <= sync2_r[5:4];
         toggle_r     <= sync2_r[0] & ~mode_prev_r;
         key_edge_r   <= sync2_r[3] & ~key_prev_r;
      end
   end

   // Divider terminal count and the candidate next phase in the current direction
   always_comb begin
      div_limit_s    = 7'(PHASE_DIV) << speed_s;
      div_last_s     = div_limit_s - 7'd1;
      div_term_s     = ({1'b0, div_cnt_r} == div_last_s);
      speed_change_s = (speed_s != speed_prev_r);
      sum_s          = {1'b0, phase_r} + STEP;
      next_phase_s   = phase_r;
      next_wrap_s    = 1'b0;
      if (dir_s) begin
         if ({1'b0, phase_r} < STEP) begin
            next_phase_s = 6'({1'b0, phase_r} + PHASE_COUNT - STEP);
            next_wrap_s  = 1'b1;
         end else begin
            next_phase_s = 6'({1'b0, phase_r} - STEP);
            next_wrap_s  = 1'b0;
         end
      end else begin
         if (sum_s >= PHASE_COUNT) begin
            next_phase_s = 6'(sum_s - PHASE_COUNT);
            next_wrap_s  = 1'b1;
         end else begin
            next_phase_s = sum_s[5:0];
            next_wrap_s  = 1'b0;
         end
      end
   end

   // Mode machine with phase divider; toggle beats freeze, leaving RUN/HOLD zeroes the phase
   always_ff @(posedge anim_clk) begin
      if (rst) begin
         state_r   <= OFF;
         phase_r   <= 6'd0;
         fancy_r   <= 1'b0;
         wrap_r    <= 1'b0;
         div_cnt_r <= 6'd0;
      end else begin
         wrap_r <= 1'b0;
         case (state_r)
            OFF: begin
               phase_r   <= 6'd0;
               div_cnt_r <= 6'd0;
               if (toggle_r) begin
                  state_r <= RUN;
                  fancy_r <= 1'b1;
               end else begin
                  state_r <= OFF;
                  fancy_r <= 1'b0;
               end
            end
            RUN: begin
               if (toggle_r) begin
                  state_r   <= OFF;
                  fancy_r   <= 1'b0;
                  phase_r   <= 6'd0;
                  div_cnt_r <= 6'd0;
               end else if (freeze_s) begin
                  state_r <= HOLD;
                  fancy_r <= 1'b1;
                  if (speed_change_s) begin
                     div_cnt_r <= 6'd0;
                  end
               end else begin
                  state_r <= RUN;
                  fancy_r <= 1'b1;
                  if (speed_change_s) begin
                     div_cnt_r <= 6'd0;
                  end else if (div_term_s) begin
                     div_cnt_r <= 6'd0;
                     phase_r   <= next_phase_s;
                     wrap_r    <= next_wrap_s;
                  end else begin
                     div_cnt_r <= div_cnt_r + 6'd1;
                  end
               end
            end
            HOLD: begin
               if (toggle_r) begin
                  state_r   <= OFF;
                  fancy_r   <= 1'b0;
                  phase_r   <= 6'd0;
                  div_cnt_r <= 6'd0;
               end else begin
                  fancy_r <= 1'b1;
                  if (freeze_s) begin
                     state_r <= HOLD;
                  end else begin
                     state_r <= RUN;
                  end
                  if (speed_change_s) begin
                     div_cnt_r <= 6'd0;
                  end
               end
            end
            default: begin
               state_r   <= OFF;
               fancy_r   <= 1'b0;
               phase_r   <= 6'd0;
               div_cnt_r <= 6'd0;
            end
         endcase
      end
   end

   // Cursor blink half-period counter; a keypress restarts in the visible half
   always_ff @(posedge anim_clk) begin
      if (rst) begin
         blink_r     <= 1'b1;
         blink_cnt_r <= {BLINK_W{1'b0}};
      end else if (key_edge_r) begin
         blink_r     <= 1'b1;
         blink_cnt_r <= {BLINK_W{1'b0}};
      end else if (blink_cnt_r == BLINK_LAST) begin
         blink_r     <= ~blink_r;
         blink_cnt_r <= {BLINK_W{1'b0}};
      end else begin
         blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      end
   end

   assign anim.phase        = phase_r;
   assign anim.fancy        = fancy_r;
   assign anim.cursor_blink = blink_r;
   assign anim.phase_wrap   = wrap_r;

endmodule

// File: tb/tb_vga_anim_sequencer.sv
// Self-checking bench for vga_anim_sequencer: directed literal checks plus a
// long randomized run compared every cycle against a behavioural model.
module tb_vga_anim_sequencer;

   localparam int P_DIV   = 1;
   localparam int P_STEP  = 1;
   localparam int P_BLINK = 6;

   logic anim_clk = 1'b0;
   logic rst      = 1'b1;

   vga_anim_sequencer_if bus ();

   vga_anim_sequencer #(
      .PHASE_DIV  (P_DIV),
      .PHASE_STEP (P_STEP),
      .BLINK_HALF (P_BLINK)
   ) dut (
      .anim_clk (anim_clk),
      .rst      (rst),
      .anim     (bus)
   );

   always #5 anim_clk = ~anim_clk;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Behavioural model state
   int  m_phase;
   bit  m_on;
   bit  m_frozen;
   bit  m_wrap;
   int  m_ticks;     // running cycles since the divider last restarted
   int  m_blink_t;   // cycles since reset or the last keypress
   // Raw input samples; index 0 = value at the previous edge
   bit       h_mode [4];
   bit       h_key  [4];
   bit       h_frz  [4];
   bit       h_dir  [4];
   bit [1:0] h_sp   [4];

   task automatic check(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
      end
   endtask

   // Reference model: sync delay seen as sample history, mode/phase/blink from the rules
   always @(posedge anim_clk) begin : model
      bit tog, kev, frz, dn, spchg;
      int lim;
      if (rst) begin
         m_phase = 0; m_on = 0; m_frozen = 0; m_wrap = 0; m_ticks = 0; m_blink_t = 0;
         for (int i = 0; i < 4; i++) begin
            h_mode[i] = 0; h_key[i] = 0; h_frz[i] = 0; h_dir[i] = 0; h_sp[i] = 2'd0;
         end
         check_en = 1'b1;
      end else begin
         tog   = h_mode[2] & ~h_mode[3];
         kev   = h_key[2] & ~h_key[3];
         frz   = h_frz[1];
         dn    = h_dir[1];
         spchg = (h_sp[1] != h_sp[2]);
         lim   = P_DIV << h_sp[1];
         m_wrap = 0;
         if (!m_on) begin
            m_phase = 0; m_ticks = 0;
            if (tog) begin m_on = 1; m_frozen = 0; end
         end else if (tog) begin
            m_on = 0; m_phase = 0; m_ticks = 0;
         end else if (m_frozen) begin
            if (!frz) m_frozen = 0;
            if (spchg) m_ticks = 0;
         end else if (frz) begin
            m_frozen = 1;
            if (spchg) m_ticks = 0;
         end else if (spchg) begin
            m_ticks = 0;
         end else begin
            m_ticks++;
            if (m_ticks % lim == 0) begin
               if (dn) begin
                  m_wrap  = (m_phase < P_STEP);
                  m_phase = (m_phase - P_STEP + 48) % 48;
               end else begin
                  m_wrap  = (m_phase + P_STEP >= 48);
                  m_phase = (m_phase + P_STEP) % 48;
               end
            end
         end
         if (kev) m_blink_t = 0;
         else     m_blink_t++;
         for (int i = 3; i > 0; i--) begin
            h_mode[i] = h_mode[i-1]; h_key[i] = h_key[i-1]; h_frz[i] = h_frz[i-1];
            h_dir[i]  = h_dir[i-1];  h_sp[i]  = h_sp[i-1];
         end
         h_mode[0] = bus.mode_btn; h_key[0] = bus.key_hit; h_frz[0] = bus.freeze;
         h_dir[0]  = bus.dir;      h_sp[0]  = bus.speed;
      end
   end

   // Compare every output against the model away from the active edge
   always @(negedge anim_clk) begin
      if (check_en) begin
         check("model_phase", int'(bus.phase), m_phase);
         check("model_fancy", int'(bus.fancy), int'(m_on));
         check("model_wrap",  int'(bus.phase_wrap), int'(m_wrap));
         check("model_blink", int'(bus.cursor_blink), int'(((m_blink_t / P_BLINK) % 2) == 0));
      end
   end

   int speed_seq [11] = '{45, 44, 44, 44, 44, 44, 43, 43, 43, 43, 42};
   int down_seq  [6]  = '{1, 2, 1, 0, 47, 46};

   // Directed stimulus with literal expectations, then randomized traffic
   initial begin
      bus.mode_btn = 1'b0; bus.freeze = 1'b0; bus.dir = 1'b0;
      bus.speed = 2'd0; bus.key_hit = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge anim_clk);
      rst = 1'b0;
      check("rst_phase", int'(bus.phase), 0);
      check("rst_fancy", int'(bus.fancy), 0);
      check("rst_blink", int'(bus.cursor_blink), 1);
      check("rst_wrap",  int'(bus.phase_wrap), 0);
      repeat (5) @(negedge anim_clk);
      check("blink_before_toggle", int'(bus.cursor_blink), 1);
      @(negedge anim_clk);
      check("blink_first_toggle", int'(bus.cursor_blink), 0);

      // Mode button pulse: fancy rises after the fourth edge, then phase counts up
      bus.mode_btn = 1'b1;
      @(negedge anim_clk);
      @(negedge anim_clk);
      bus.mode_btn = 1'b0;
      check("fancy_after_e1", int'(bus.fancy), 0);
      @(negedge anim_clk);
      check("fancy_after_e2", int'(bus.fancy), 0);
      @(negedge anim_clk);
      check("fancy_after_e3", int'(bus.fancy), 1);
      check("phase_enter_run", int'(bus.phase), 0);
      for (int k = 1; k <= 48; k++) begin
         @(negedge anim_clk);
         check("up_phase", int'(bus.phase), k % 48);
         check("up_wrap",  int'(bus.phase_wrap), int'(k == 48));
      end

      // Direction change takes effect two edges later, then wraps downward
      bus.dir = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge anim_clk);
         check("down_phase", int'(bus.phase), down_seq[k]);
         check("down_wrap",  int'(bus.phase_wrap), int'(down_seq[k] == 47));
      end

      // Speed 2: divider restarts on the change, then one advance per 4 cycles
      bus.speed = 2'd2;
      for (int k = 0; k < 11; k++) begin
         @(negedge anim_clk);
         check("speed_phase", int'(bus.phase), speed_seq[k]);
      end

      // Mode and freeze together end in OFF with phase 0
      bus.mode_btn = 1'b1; bus.freeze = 1'b1;
      @(negedge anim_clk);
      @(negedge anim_clk);
      bus.mode_btn = 1'b0;
      @(negedge anim_clk);
      @(negedge anim_clk);
      check("modefrz_fancy", int'(bus.fancy), 0);
      check("modefrz_phase", int'(bus.phase), 0);
      bus.freeze = 1'b0; bus.speed = 2'd0; bus.dir = 1'b0;

      // Randomized control traffic with occasional resets
      for (int n = 0; n < 6000; n++) begin
         @(negedge anim_clk);
         rst = ($urandom_range(0, 699) == 0);
         if ($urandom_range(0, 47) == 0) bus.mode_btn = ~bus.mode_btn;
         if ($urandom_range(0, 39) == 0) bus.freeze   = ~bus.freeze;
         if ($urandom_range(0, 29) == 0) bus.dir      = ~bus.dir;
         if ($urandom_range(0, 79) == 0) bus.speed    = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) bus.key_hit  = ~bus.key_hit;
      end
      rst = 1'b0;
      @(negedge anim_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
